// File: rtl/equiv_vector_sequencer.sv
// Stimulus sequencer and checker for golden-vs-netlist equivalence runs:
// an exhaustive 2-input sweep, then LFSR vectors, counting output mismatches.
module equiv_vector_sequencer #(
  parameter int          NUM_RANDOM    = 500,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c_golden,
  input  logic             c_netlist,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [CNT_W-1:0] vec_idx
);

  localparam logic [15:0]      SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [31:0]      LAST_IDX    = 32'(NUM_RANDOM + 3);
  localparam int               SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALL_ONES    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t          state_r;
  logic [15:0]     lfsr_r;
  logic [31:0]     idx_r;
  logic [SC_W-1:0] settle_cnt_r;
  logic            mismatch_s;

  // Galois LFSR, taps 0xB400, shifting right
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Case inequality so an X/Z on either side is reported as a failure
  assign mismatch_s = (c_golden !== c_netlist);
  // Index kept wide internally so a narrow CNT_W cannot truncate the run length
  assign vec_idx    = idx_r[CNT_W-1:0];

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      a              <= 1'b0;
      b              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= ALL_ONES;
      idx_r          <= 32'd0;
      lfsr_r         <= SEED_EFF;
      settle_cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE, FINISH: begin
          if (start) begin
            state_r        <= DRIVE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= ALL_ONES;
            idx_r          <= 32'd0;
            lfsr_r         <= SEED_EFF;
          end else if (state_r == FINISH) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (mismatch_cnt == '0);
          end else begin
            state_r <= IDLE;
          end
        end
        DRIVE: begin
          if (idx_r < 32'd4) begin
            a <= idx_r[0];
            b <= idx_r[1];
          end else begin
            a      <= lfsr_r[0];
            b      <= lfsr_r[1];
            lfsr_r <= lfsr_step(lfsr_r);
          end
          settle_cnt_r <= '0;
          state_r      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= COMPARE;
          end else begin
            settle_cnt_r <= settle_cnt_r + SC_W'(1);
          end
        end
        COMPARE: begin
          if (mismatch_s) begin
            if (mismatch_cnt != ALL_ONES) begin
              mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
            if (first_fail_idx == ALL_ONES) begin
              first_fail_idx <= vec_idx;
            end
          end
          if (idx_r == LAST_IDX) begin
            state_r <= FINISH;
          end else begin
            idx_r   <= idx_r + 32'd1;
            state_r <= DRIVE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_vector_sequencer.sv
// Self-checking bench for equiv_vector_sequencer: three configurations checked
// against a vector/mismatch reference model derived from the schedule rules.
module tb_equiv_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst, start0, start1, start2;
  logic        a0, b0, busy0, done0, pass0;
  logic [15:0] cnt0, ff0, vi0;
  logic        a1, b1, busy1, done1, pass1;
  logic [15:0] cnt1, ff1, vi1;
  logic        a2, b2, busy2, done2, pass2;
  logic [2:0]  cnt2, ff2, vi2;
  logic        cg0, cg1, cg2, cn0, cn1, cn2;
  int          mode0, mode1;
  logic [63:0] mask0;
  logic        x_bit;
  int          errors = 0;
  int          checks = 0;
  logic        ea [0:11];
  logic        eb [0:11];

  always #5 clk = ~clk;

  equiv_vector_sequencer #(.NUM_RANDOM(8), .SETTLE_CYCLES(1), .LFSR_SEED(16'hACE1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c_golden(cg0), .c_netlist(cn0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(cnt0), .first_fail_idx(ff0), .vec_idx(vi0));
  equiv_vector_sequencer #(.NUM_RANDOM(0), .SETTLE_CYCLES(3), .LFSR_SEED(16'hACE1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_golden(cg1), .c_netlist(cn1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1), .first_fail_idx(ff1), .vec_idx(vi1));
  equiv_vector_sequencer #(.NUM_RANDOM(8), .SETTLE_CYCLES(1), .LFSR_SEED(16'hACE1), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_golden(cg2), .c_netlist(cn2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2), .first_fail_idx(ff2), .vec_idx(vi2));

  // Golden AND gates and the emulated post-route netlists
  assign cg0 = a0 & b0;
  assign cg1 = a1 & b1;
  assign cg2 = a2 & b2;
  assign cn1 = (mode1 == 1) ? 1'b0 : (a1 & b1);
  assign cn2 = ~(a2 & b2);
  always_comb begin
    case (mode0)
      0:       cn0 = a0 & b0;
      2:       cn0 = ~(a0 & b0);
      3:       cn0 = (vi0 == 16'd2) ? x_bit : (a0 & b0);
      default: cn0 = (a0 & b0) ^ mask0[vi0[5:0]];
    endcase
  end

  // Reference schedule: exhaustive sweep then Galois LFSR (taps 0xB400) bits
  task automatic build_vecs();
    int l;
    l = 'hACE1;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        ea[i] = logic'(i % 2);
        eb[i] = logic'(i / 2);
      end else begin
        ea[i] = logic'(l % 2);
        eb[i] = logic'((l / 2) % 2);
        l = (l % 2 == 1) ? ((l / 2) ^ 'hB400) : (l / 2);
      end
    end
  endtask

  function automatic logic model_net(input int mode, input int i, input logic [63:0] mask);
    logic g;
    g = ea[i] & eb[i];
    case (mode)
      0:       return g;
      1:       return 1'b0;
      2:       return ~g;
      3:       return (i == 2) ? x_bit : g;
      default: return g ^ mask[i];
    endcase
  endfunction

  // One full run on u0 (12 vectors, settle 1) with an optional ignored start pulse
  task automatic run0(input int mode, input logic [63:0] mask, input int glitch_n, input string tag);
    int          exp_cnt;
    logic [15:0] exp_ff;
    int          k;
    mode0 = mode;
    mask0 = mask;
    exp_cnt = 0;
    exp_ff = 16'hFFFF;
    for (int i = 0; i < 12; i++) begin
      if (model_net(mode, i, mask) !== (ea[i] & eb[i])) begin
        exp_cnt++;
        if (exp_ff == 16'hFFFF) exp_ff = 16'(i);
      end
    end
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++; $display("FAIL %s start: busy=%b done=%b, expected busy=1 done=0", tag, busy0, done0);
    end
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk);
      start0 = (n == glitch_n);
      if (n >= 2 && (n - 2) % 3 == 0) begin
        k = (n - 2) / 3;
        checks++;
        if ({a0, b0, vi0} !== {ea[k], eb[k], 16'(k)}) begin
          errors++; $display("FAIL %s vec%0d: a,b,idx=%b,%b,%0d expected %b,%b,%0d", tag, k, a0, b0, vi0, ea[k], eb[k], k);
        end
      end
      if (n == 36) begin
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1) begin
          errors++; $display("FAIL %s early_done: done=%b busy=%b at cycle 36", tag, done0, busy0);
        end
      end
    end
    start0 = 1'b0;
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL %s done_time: done=%b busy=%b at cycle 37, expected 1/0", tag, done0, busy0);
    end
    checks++;
    if (cnt0 !== 16'(exp_cnt) || ff0 !== exp_ff || pass0 !== (exp_cnt == 0)) begin
      errors++; $display("FAIL %s result: cnt=%0d ff=%h pass=%b expected cnt=%0d ff=%h pass=%b",
                         tag, cnt0, ff0, pass0, exp_cnt, exp_ff, (exp_cnt == 0));
    end
  endtask

  task automatic run1(input int mode, input int exp_cnt, input logic [15:0] exp_ff, input string tag);
    mode1 = mode;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      if (n >= 4 && (n - 4) % 5 == 0) begin
        checks++;
        if ({a1, b1} !== {ea[(n - 4) / 5], eb[(n - 4) / 5]}) begin
          errors++; $display("FAIL %s vec%0d: a,b=%b,%b expected %b,%b", tag, (n - 4) / 5, a1, b1, ea[(n - 4) / 5], eb[(n - 4) / 5]);
        end
      end
      if (n == 20) begin
        checks++;
        if (done1 !== 1'b0) begin errors++; $display("FAIL %s early_done: done=1 at cycle 20", tag); end
      end
    end
    checks++;
    if (done1 !== 1'b1 || cnt1 !== 16'(exp_cnt) || ff1 !== exp_ff || pass1 !== (exp_cnt == 0)) begin
      errors++; $display("FAIL %s result: done=%b cnt=%0d ff=%h pass=%b expected 1,%0d,%h,%b",
                         tag, done1, cnt1, ff1, pass1, exp_cnt, exp_ff, (exp_cnt == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if ({a0, b0, busy0, done0, pass0, cnt0, ff0, vi0} !== {5'b00000, 16'h0000, 16'hFFFF, 16'h0000}) begin
        errors++; $display("FAIL reset_idle: a=%b b=%b busy=%b done=%b pass=%b cnt=%h ff=%h idx=%h, expected 0s with ff=ffff",
                           a0, b0, busy0, done0, pass0, cnt0, ff0, vi0);
      end
    end
    checks++;
    if (ff2 !== 3'b111 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_other: ff2=%b busy1=%b expected 111/0", ff2, busy1);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) if (exp_cnt < 7) exp_cnt++;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (37) @(negedge clk);
    checks++;
    if (done2 !== 1'b1 || cnt2 !== 3'(exp_cnt) || ff2 !== 3'd0 || pass2 !== 1'b0) begin
      errors++; $display("FAIL saturation: done=%b cnt=%0d ff=%0d pass=%b expected 1,%0d,0,0", done2, cnt2, ff2, pass2, exp_cnt);
    end
  endtask

  task automatic test_rst_midrun();
    mode0 = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1; start0 = 1'b1;
    @(negedge clk); rst = 1'b0; start0 = 1'b0;
    checks++;
    if ({a0, b0, busy0, done0, pass0, cnt0, ff0, vi0} !== {5'b00000, 16'h0000, 16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL rst_midrun: a=%b b=%b busy=%b done=%b cnt=%h ff=%h idx=%h, expected reset values",
                         a0, b0, busy0, done0, cnt0, ff0, vi0);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL rst_abort: busy=%b done=%b after abort, expected 0/0", busy0, done0);
    end
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 3; r++) begin
      run0(4, {$urandom, $urandom}, int'($urandom_range(1, 35)), "random_faults");
    end
  endtask

  initial begin
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = 0; mode1 = 0; mask0 = 64'd0; x_bit = 1'bx;
    build_vecs();
    test_reset();
    run0(0, 64'd0, -1, "perfect");
    run0(0, 64'd0, 4, "start_ignored");
    run0(2, 64'd0, -1, "inverted");
    run0(3, 64'd0, -1, "xprop");
    run1(1, 1, 16'd3, "stuck0");
    run1(0, 0, 16'hFFFF, "settle3_perfect");
    test_saturation();
    test_random_faults();
    test_rst_midrun();
    run0(0, 64'd0, -1, "back_to_back_1");
    run0(2, 64'd0, -1, "back_to_back_2");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
